mem_port_arbiter: RTL and testbench

- Sequences the single shared memory port between the instruction-fetch stage and the load/store stage of the pipelined core.
- Grants one access at a time and holds the stage registers (IF and L/S) stalled while their access is pending.
- Returns registered read data with a one-cycle done pulse.
- Contains a wait-timeout guard that aborts hung accesses and raises a sticky error.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the memory-port arbiter and its neighbours:
// the IF stage, the L/S stage and the single shared memory port.
interface mem_port_arbiter_if #(
  parameter int XLEN = 64
);
  // Instruction-fetch side
  logic            if_req_i;
  logic [XLEN-1:0] if_addr_i;
  logic            if_done_o;
  logic [31:0]     if_rdata_o;
  // Load/store side
  logic            ls_req_i;
  logic            ls_we_i;
  logic [XLEN-1:0] ls_addr_i;
  logic [XLEN-1:0] ls_wdata_i;
  logic [7:0]      ls_wmask_i;
  logic            ls_done_o;
  logic [XLEN-1:0] ls_rdata_o;
  // Shared memory port
  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [7:0]      mem_wmask_o;
  logic            mem_ack_i;
  logic [XLEN-1:0] mem_rdata_i;
  // Pipeline control and status
  logic            stall_if_o;
  logic            stall_ls_o;
  logic            err_o;

  // Arbiter view
  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    input  mem_ack_i, mem_rdata_i,
    output if_done_o, if_rdata_o, ls_done_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output stall_if_o, stall_ls_o, err_o
  );

  // Environment view (pipeline stages plus memory)
  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    output mem_ack_i, mem_rdata_i,
    input  if_done_o, if_rdata_o, ls_done_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  stall_if_o, stall_ls_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// L/S has fixed priority (older instruction). Each access runs
// IDLE -> BUSY -> RESP; a hung access is aborted after TIMEOUT BUSY cycles
// and leaves a sticky error flag behind.
module mem_port_arbiter #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;
  typedef enum logic       {OWN_IF, OWN_LS}         owner_e;

  state_e            state_q,  state_d;
  owner_e            owner_q,  owner_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              err_q,    err_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [XLEN-1:0]   mem_addr_q,  mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [7:0]        mem_wmask_q, mem_wmask_d;
  logic              if_done_q,   if_done_d;
  logic              ls_done_q,   ls_done_d;
  logic [31:0]       if_rdata_q,  if_rdata_d;
  logic [XLEN-1:0]   ls_rdata_q,  ls_rdata_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state logic: arbitration, wait/timeout tracking and response capture.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    // Done pulses and read data live only for the single RESP cycle.
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    if_rdata_d  = '0;
    ls_rdata_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.ls_req_i) begin
          owner_d     = OWN_LS;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.ls_we_i;
          mem_addr_d  = bus.ls_addr_i;
          mem_wdata_d = bus.ls_wdata_i;
          mem_wmask_d = bus.ls_wmask_i;
          state_d     = S_BUSY;
        end else if (bus.if_req_i) begin
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr_i;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
          state_d     = S_BUSY;
        end
      end

      S_BUSY: begin
        if (bus.mem_ack_i || (cnt_inc == CNT_W'(TIMEOUT))) begin
          // Both completion and abort release the port and respond once.
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
          cnt_d       = '0;
          state_d     = S_RESP;
          if (owner_q == OWN_IF) if_done_d = 1'b1;
          else                   ls_done_d = 1'b1;
          if (bus.mem_ack_i) begin
            // Fetch picks the 32-bit half of the doubleword; stores return 0.
            if (owner_q == OWN_IF)
              if_rdata_d = mem_addr_q[2] ? bus.mem_rdata_i[63:32] : bus.mem_rdata_i[31:0];
            else if (!mem_we_q)
              ls_rdata_d = bus.mem_rdata_i;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset of every flop, datapath included.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_wmask_o = mem_wmask_q;
  assign bus.if_done_o   = if_done_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.ls_done_o   = ls_done_q;
  assign bus.ls_rdata_o  = ls_rdata_q;
  assign bus.err_o       = err_q;

  // Stalls follow the live requests so a stage is released in its done cycle.
  assign bus.stall_ls_o = bus.ls_req_i & ~ls_done_q;
  assign bus.stall_if_o = (bus.if_req_i & ~if_done_q) | bus.stall_ls_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Expected responses are queued when a
// request is issued and popped by a monitor when a done pulse appears.
// A second instance with TIMEOUT=4 covers the abort path.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.XLEN(64)) b1 ();
  mem_port_arbiter_if #(.XLEN(64)) b2 ();

  mem_port_arbiter #(.XLEN(64), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  mem_port_arbiter #(.XLEN(64), .TIMEOUT(4)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  typedef struct {
    bit          is_ls;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the port busy for 'delay' cycles, then ack with rdata.
  task automatic serve(input int delay, input logic [63:0] rdata, input logic [63:0] exp_addr,
                       input logic exp_stall_ls, input string tag);
    for (int i = 0; i < delay; i++) begin
      check({tag, "_req_hold"},   b1.mem_req_o,  1);
      check({tag, "_addr_hold"},  b1.mem_addr_o, exp_addr);
      check({tag, "_stall_ls"},   b1.stall_ls_o, exp_stall_ls);
      tick();
    end
    check({tag, "_req_at_ack"},  b1.mem_req_o,  1);
    check({tag, "_addr_at_ack"}, b1.mem_addr_o, exp_addr);
    b1.mem_ack_i   = 1'b1;
    b1.mem_rdata_i = rdata;
    tick();
    b1.mem_ack_i   = 1'b0;
    b1.mem_rdata_i = '0;
  endtask

  // Scoreboard monitor: every done pulse of the main instance pops one entry.
  always @(negedge clk) begin
    if (!rst && (b1.if_done_o || b1.ls_done_o)) begin
      n_vec++;
      assert (sb.size() > 0 && !(b1.if_done_o && b1.ls_done_o)) else begin
        n_err++;
        $error("FAIL sb_unexpected_done: observed if=%0b ls=%0b pending=%0d expected one done with pending>0",
               b1.if_done_o, b1.ls_done_o, sb.size());
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_owner", {63'd0, b1.ls_done_o}, {63'd0, e.is_ls});
        if (e.is_ls) check("sb_ls_rdata", b1.ls_rdata_o, e.data);
        else         check("sb_if_rdata", {32'd0, b1.if_rdata_o}, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rises[4];
    int nr;
    logic prev;

    b1.if_req_i = 0; b1.if_addr_i = '0;
    b1.ls_req_i = 0; b1.ls_we_i = 0; b1.ls_addr_i = '0; b1.ls_wdata_i = '0; b1.ls_wmask_i = '0;
    b1.mem_ack_i = 0; b1.mem_rdata_i = '0;
    b2.if_req_i = 0; b2.if_addr_i = '0;
    b2.ls_req_i = 0; b2.ls_we_i = 0; b2.ls_addr_i = '0; b2.ls_wdata_i = '0; b2.ls_wmask_i = '0;
    b2.mem_ack_i = 0; b2.mem_rdata_i = '0;

    // ---- Reset state
    tick(); tick();
    check("rst_mem_req",  b1.mem_req_o,  0);
    check("rst_mem_addr", b1.mem_addr_o, 0);
    check("rst_if_done",  b1.if_done_o,  0);
    check("rst_ls_done",  b1.ls_done_o,  0);
    check("rst_err",      b1.err_o,      0);
    check("rst_stall_if", b1.stall_if_o, 0);
    rst = 1'b0;

    // ---- Single fetch, ack one cycle after mem_req_o
    b1.if_req_i  = 1'b1;
    b1.if_addr_i = 64'h0000_0000_8000_0004;
    sb.push_back('{is_ls: 1'b0, data: 64'h1111_2222});
    tick();
    check("if1_mem_req",  b1.mem_req_o,  1);
    check("if1_mem_addr", b1.mem_addr_o, 64'h8000_0004);
    check("if1_mem_we",   b1.mem_we_o,   0);
    check("if1_stall_if", b1.stall_if_o, 1);
    serve(0, 64'h1111_2222_3333_4444, 64'h8000_0004, 1'b0, "if1");
    check("if1_done",     b1.if_done_o,  1);
    check("if1_rdata",    b1.if_rdata_o, 64'h1111_2222);
    check("if1_req_drop", b1.mem_req_o,  0);
    b1.if_req_i = 1'b0;
    tick();
    check("if1_done_end", b1.if_done_o,  0);

    // ---- Simultaneous IF + LS store: LS first, then IF
    b1.ls_req_i = 1; b1.ls_we_i = 1; b1.ls_addr_i = 64'h100; b1.ls_wdata_i = 64'hAB; b1.ls_wmask_i = 8'h01;
    b1.if_req_i = 1; b1.if_addr_i = 64'h200;
    sb.push_back('{is_ls: 1'b1, data: 64'h0});
    sb.push_back('{is_ls: 1'b0, data: 64'h9ABC_DEF0});
    tick();
    check("arb_mem_we",    b1.mem_we_o,    1);
    check("arb_mem_addr",  b1.mem_addr_o,  64'h100);
    check("arb_mem_mask",  b1.mem_wmask_o, 8'h01);
    check("arb_mem_wdata", b1.mem_wdata_o, 64'hAB);
    check("arb_stall_if",  b1.stall_if_o,  1);
    serve(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h100, 1'b1, "arb_ls");
    check("arb_ls_done",   b1.ls_done_o,   1);
    check("arb_if_nodone", b1.if_done_o,   0);
    check("arb_stall_ls",  b1.stall_ls_o,  0);
    check("arb_stall_if2", b1.stall_if_o,  1);
    b1.ls_req_i = 0; b1.ls_we_i = 0; b1.ls_wdata_i = '0; b1.ls_wmask_i = '0;
    tick();
    check("arb_idle_req",  b1.mem_req_o,   0);
    check("arb_idle_stall", b1.stall_if_o, 1);
    tick();
    check("arb_if_req",    b1.mem_req_o,   1);
    check("arb_if_we",     b1.mem_we_o,    0);
    check("arb_if_addr",   b1.mem_addr_o,  64'h200);
    check("arb_if_mask",   b1.mem_wmask_o, 0);
    serve(0, 64'h1234_5678_9ABC_DEF0, 64'h200, 1'b0, "arb_if");
    check("arb_if_done",   b1.if_done_o,   1);
    b1.if_req_i = 0;
    tick();

    // ---- LS load with ack delayed 5 cycles (6 BUSY cycles)
    b1.ls_req_i = 1; b1.ls_we_i = 0; b1.ls_addr_i = 64'h208; b1.ls_wmask_i = 8'hFF;
    sb.push_back('{is_ls: 1'b1, data: 64'hDEAD_BEEF});
    tick();
    serve(5, 64'h0000_0000_DEAD_BEEF, 64'h208, 1'b1, "ld");
    check("ld_done",       b1.ls_done_o,   1);
    check("ld_rdata",      b1.ls_rdata_o,  64'hDEAD_BEEF);
    b1.ls_req_i = 0; b1.ls_wmask_i = '0;
    tick();
    check("ld_done_once",  b1.ls_done_o,   0);
    check("ld_rdata_clr",  b1.ls_rdata_o,  0);

    // ---- Back-to-back fetches with ack held high: grants 3 cycles apart
    b1.if_req_i = 1; b1.if_addr_i = 64'h0C;
    b1.mem_ack_i = 1; b1.mem_rdata_i = 64'h5555_6666_7777_8888;
    for (int k = 0; k < 3; k++) sb.push_back('{is_ls: 1'b0, data: 64'h5555_6666});
    nr = 0;
    prev = b1.mem_req_o;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (b1.mem_req_o && !prev && nr < 4) begin
        rises[nr] = t;
        nr++;
      end
      prev = b1.mem_req_o;
      if (t == 8) b1.if_req_i = 0;
    end
    tick();
    b1.mem_ack_i = 0; b1.mem_rdata_i = '0;
    check("b2b_grants", nr, 3);
    if (nr >= 3) begin
      check("b2b_gap1", rises[1] - rises[0], 3);
      check("b2b_gap2", rises[2] - rises[1], 3);
    end
    check("b2b_idle", b1.mem_req_o, 0);

    // ---- Reset while BUSY with a same-cycle ack: no done pulse
    b1.if_req_i = 1; b1.if_addr_i = 64'h40;
    tick();
    check("rb_busy", b1.mem_req_o, 1);
    rst = 1; b1.mem_ack_i = 1; b1.mem_rdata_i = 64'hFFFF_0000_FFFF_0000; b1.if_req_i = 0;
    tick();
    check("rb_mem_req",  b1.mem_req_o,  0);
    check("rb_mem_addr", b1.mem_addr_o, 0);
    check("rb_if_done",  b1.if_done_o,  0);
    check("rb_if_rdata", b1.if_rdata_o, 0);
    check("rb_stall_if", b1.stall_if_o, 0);
    rst = 0; b1.mem_ack_i = 0; b1.mem_rdata_i = '0;
    tick();
    check("rb_no_done",  b1.if_done_o,  0);
    check("rb_idle",     b1.mem_req_o,  0);

    // ---- Timeout instance (TIMEOUT=4): abort, sticky error, late ack ignored
    b2.ls_req_i = 1; b2.ls_we_i = 0; b2.ls_addr_i = 64'h300;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("to_req_busy", b2.mem_req_o, 1);
      tick();
    end
    check("to_req_drop", b2.mem_req_o,  0);
    check("to_done",     b2.ls_done_o,  1);
    check("to_rdata",    b2.ls_rdata_o, 0);
    check("to_err",      b2.err_o,      1);
    b2.ls_req_i = 0;
    b2.mem_ack_i = 1; b2.mem_rdata_i = 64'h0123_4567_89AB_CDEF;
    tick();
    check("to_late_done", b2.ls_done_o,  0);
    check("to_late_data", b2.ls_rdata_o, 0);
    check("to_err_stick", b2.err_o,      1);
    tick();
    b2.mem_ack_i = 0; b2.mem_rdata_i = '0;
    tick();
    check("to_err_stick2", b2.err_o,     1);
    check("to_idle_req",   b2.mem_req_o, 0);
    rst = 1;
    tick();
    check("to_err_clr",  b2.err_o, 0);
    rst = 0;
    tick();

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
